// File: rtl/param_data_mem.sv
// Single-port 32-bit data memory with byte/half/word access, programmable wait states
// and self-initialisation after reset (zero fill or word i = i).
module param_data_mem #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1,
    parameter int INIT_MODE   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        init_done
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} state_t;

    state_t        state_reg, state_next;
    logic [AW-1:0] cnt_reg, cnt_next;
    logic          write_reg, write_next;
    logic          signed_reg, signed_next;
    logic [1:0]    size_reg, size_next;
    logic [31:0]   addr_reg, addr_next;
    logic [31:0]   wdata_reg, wdata_next;
    logic [31:0]   rsp_rdata_reg, rsp_rdata_next;
    logic          rsp_err_reg, rsp_err_next;

    logic          access;
    logic          acc_err;
    logic [3:0]    lane_sel;
    logic [3:0]    lane_we;
    logic [31:0]   store_word;
    logic [31:0]   mem_wdata;
    logic [31:0]   rd_word;
    logic [31:0]   load_data;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;
    logic [AW-1:0] mem_waddr, mem_raddr;

    assign access  = (state_reg == WAIT) && (cnt_reg == '0);
    assign acc_err = (|addr_reg[31:AW+2]) || (size_reg == 2'd3) ||
                     (size_reg == 2'd1 && addr_reg[0]) ||
                     (size_reg == 2'd2 && addr_reg[1:0] != 2'b00);

    always_comb begin
        lane_sel   = 4'b1111;
        store_word = wdata_reg;
        case (size_reg)
            2'd0: begin
                lane_sel   = 4'b0001 << addr_reg[1:0];
                store_word = {4{wdata_reg[7:0]}};
            end
            2'd1: begin
                lane_sel   = addr_reg[1] ? 4'b1100 : 4'b0011;
                store_word = {2{wdata_reg[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (addr_reg[1:0])
            2'd0:    byte_v = rd_word[7:0];
            2'd1:    byte_v = rd_word[15:8];
            2'd2:    byte_v = rd_word[23:16];
            default: byte_v = rd_word[31:24];
        endcase
        half_v = addr_reg[1] ? rd_word[31:16] : rd_word[15:0];
        case (size_reg)
            2'd0:    load_data = signed_reg ? {{24{byte_v[7]}}, byte_v} : {24'd0, byte_v};
            2'd1:    load_data = signed_reg ? {{16{half_v[15]}}, half_v} : {16'd0, half_v};
            default: load_data = rd_word;
        endcase
    end

    // Reads in IDLE follow the incoming address so the word is ready by the access edge
    assign mem_raddr = (state_reg == IDLE) ? req_addr[AW+1:2] : addr_reg[AW+1:2];
    assign mem_waddr = (state_reg == INIT) ? cnt_reg : addr_reg[AW+1:2];
    assign mem_wdata = (state_reg == INIT) ? ((INIT_MODE == 1) ? 32'(cnt_reg) : 32'd0)
                                           : store_word;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] rd_byte_reg;

            assign lane_we[gi] = (state_reg == INIT) ||
                                 (access && write_reg && !acc_err && lane_sel[gi]);

            always_ff @(posedge clk) begin
                if (lane_we[gi])
                    lane_mem[mem_waddr] <= mem_wdata[8*gi +: 8];
                rd_byte_reg <= lane_mem[mem_raddr];
            end

            assign rd_word[8*gi +: 8] = rd_byte_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= INIT;
            cnt_reg       <= '0;
            write_reg     <= 1'b0;
            signed_reg    <= 1'b0;
            size_reg      <= 2'd0;
            addr_reg      <= 32'd0;
            wdata_reg     <= 32'd0;
            rsp_rdata_reg <= 32'd0;
            rsp_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            write_reg     <= write_next;
            signed_reg    <= signed_next;
            size_reg      <= size_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_err_reg   <= rsp_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        write_next     = write_reg;
        signed_next    = signed_reg;
        size_next      = size_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_err_next   = rsp_err_reg;
        case (state_reg)
            INIT: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == AW'(DEPTH - 1)) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end
            IDLE: begin
                if (req_valid) begin
                    write_next  = req_write;
                    signed_next = req_signed;
                    size_next   = req_size;
                    addr_next   = req_addr;
                    wdata_next  = req_wdata;
                    cnt_next    = AW'(WAIT_CYCLES);
                    state_next  = WAIT;
                end
            end
            WAIT: begin
                if (cnt_reg == '0) begin
                    state_next     = RESP;
                    rsp_err_next   = acc_err;
                    rsp_rdata_next = (acc_err || write_reg) ? 32'd0 : load_data;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = INIT;
        endcase
    end

    assign req_ready = (state_reg == IDLE);
    assign rsp_valid = (state_reg == RESP);
    assign init_done = (state_reg != INIT);
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_param_data_mem.sv
// Directed bench for param_data_mem (DEPTH=256, WAIT_CYCLES=3, INIT_MODE=1):
// init timing, lane stores/loads, error cases, latency/throughput and reset abort.
module tb_param_data_mem;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        init_done;

    int nvec = 0;
    int nerr = 0;

    param_data_mem #(.DEPTH(256), .WAIT_CYCLES(3), .INIT_MODE(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .init_done  (init_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic do_req(input logic w, input logic [31:0] a, input logic [1:0] s,
                          input logic sg, input logic [31:0] d,
                          output logic [31:0] rd, output logic er, output int lat);
        int n;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("ready_timeout", 32'd0, 32'd1);
        req_write  = w;
        req_addr   = a;
        req_size   = s;
        req_signed = sg;
        req_wdata  = d;
        req_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        // scramble inputs: the access must use only the values latched at acceptance
        req_valid  = 1'b0;
        req_write  = ~w;
        req_addr   = 32'hFFFF_FFFF;
        req_size   = 2'd3;
        req_signed = ~sg;
        req_wdata  = 32'h5A5A_5A5A;
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) check("rsp_timeout", 32'd0, 32'd1);
        rd = rsp_rdata;
        er = rsp_err;
    endtask

    task automatic access_chk(input string tag, input logic w, input logic [31:0] a,
                              input logic [1:0] s, input logic sg, input logic [31:0] d,
                              input logic [31:0] exp_data, input logic exp_err);
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(w, a, s, sg, d, rd, er, lat);
        check({tag, "_data"}, rd, exp_data);
        check({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
    endtask

    task automatic wait_init(input string tag, input int exp_cycles);
        int n;
        int first;
        first = 0;
        n = 0;
        while (first == 0 && n < 1000) begin
            @(negedge clk);
            n++;
            if (init_done) first = n;
        end
        check(tag, 32'(first), 32'(exp_cycles));
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [6:0]  ready_seq, valid_seq;
    int          n;

    initial begin
        // reset state
        #23;
        check("rst_ready", {31'd0, req_ready}, 32'd0);
        check("rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_init_done", {31'd0, init_done}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", {31'd0, rsp_err}, 32'd0);

        @(negedge clk);
        rst = 1'b1;
        wait_init("init_cycles", 256);

        do_req(1'b0, 32'h0000_0010, 2'd2, 1'b0, 32'd0, rd, er, lat);
        check("ld10_data", rd, 32'h0000_0004);
        check("ld10_err", {31'd0, er}, 32'd0);
        check("ld10_latency", 32'(lat), 32'd5);

        access_chk("st20_word", 1'b1, 32'h20, 2'd2, 1'b0, 32'h8899_AABB, 32'd0, 1'b0);
        access_chk("st21_byte", 1'b1, 32'h21, 2'd0, 1'b0, 32'hFFFF_FF11, 32'd0, 1'b0);
        access_chk("ld20_word", 1'b0, 32'h20, 2'd2, 1'b1, 32'd0, 32'h8899_11BB, 1'b0);
        access_chk("ld23_bs",   1'b0, 32'h23, 2'd0, 1'b1, 32'd0, 32'hFFFF_FF88, 1'b0);
        access_chk("ld23_bu",   1'b0, 32'h23, 2'd0, 1'b0, 32'd0, 32'h0000_0088, 1'b0);
        access_chk("ld22_hs",   1'b0, 32'h22, 2'd1, 1'b1, 32'd0, 32'hFFFF_8899, 1'b0);
        access_chk("ld20_hu",   1'b0, 32'h20, 2'd1, 1'b0, 32'd0, 32'h0000_11BB, 1'b0);
        access_chk("ld21_bs",   1'b0, 32'h21, 2'd0, 1'b1, 32'd0, 32'h0000_0011, 1'b0);
        access_chk("st26_half", 1'b1, 32'h26, 2'd1, 1'b0, 32'h0000_CAFE, 32'd0, 1'b0);
        access_chk("ld24_word", 1'b0, 32'h24, 2'd2, 1'b0, 32'd0, 32'hCAFE_0009, 1'b0);

        // faulting requests; out-of-range store would alias onto word 0 if not blocked
        access_chk("ld402_err", 1'b0, 32'h0000_0402, 2'd2, 1'b0, 32'd0, 32'd0, 1'b1);
        access_chk("ld401_err", 1'b0, 32'h0000_0401, 2'd1, 1'b0, 32'd0, 32'd0, 1'b1);
        access_chk("sz3_err",   1'b0, 32'h0000_0100, 2'd3, 1'b0, 32'd0, 32'd0, 1'b1);
        access_chk("st400_err", 1'b1, 32'h0000_0400, 2'd2, 1'b0, 32'h1234_5678, 32'd0, 1'b1);
        access_chk("st101_err", 1'b1, 32'h0000_0101, 2'd1, 1'b0, 32'h0000_BEEF, 32'd0, 1'b1);
        access_chk("st102_err", 1'b1, 32'h0000_0102, 2'd2, 1'b0, 32'hDEAD_0000, 32'd0, 1'b1);
        access_chk("ld100_keep", 1'b0, 32'h0000_0100, 2'd2, 1'b0, 32'd0, 32'h0000_0040, 1'b0);
        access_chk("ld000_keep", 1'b0, 32'h0000_0000, 2'd2, 1'b0, 32'd0, 32'h0000_0000, 1'b0);

        // held req_valid: ready low through WAIT x4 and RESP, re-accept one IDLE cycle later
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        req_write = 1'b0;
        req_addr  = 32'h0000_0010;
        req_size  = 2'd2;
        req_valid = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            ready_seq[k] = req_ready;
            valid_seq[k] = rsp_valid;
        end
        req_valid = 1'b0;
        check("held_ready_seq", {25'd0, ready_seq}, {25'd0, 7'b0100000});
        check("held_valid_seq", {25'd0, valid_seq}, {25'd0, 7'b0010000});
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("held_second_rsp", rsp_rdata, 32'h0000_0004);

        // reset in the middle of a store's WAIT phase
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        req_write = 1'b1;
        req_addr  = 32'h0000_0040;
        req_size  = 2'd2;
        req_wdata = 32'hDEAD_BEEF;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("abort_ready", {31'd0, req_ready}, 32'd0);
        check("abort_valid", {31'd0, rsp_valid}, 32'd0);
        check("abort_init_done", {31'd0, init_done}, 32'd0);
        check("abort_rdata", rsp_rdata, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        wait_init("reinit_cycles", 256);
        access_chk("ld40_reinit", 1'b0, 32'h0000_0040, 2'd2, 1'b0, 32'd0, 32'h0000_0010, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "time limit");
    end
endmodule
